lfsr_10_chk: RTL

Serial PRBS checker for the 10-bit X^10+X^7+1 LFSR pattern generated elsewhere in the lab design. It receives the generator's serial output bit stream, self-synchronizes by seeding a local LFSR from the received bits, and declares lock after a run of correct predictions. Once locked, it flags and counts bit errors. It sits at the receive end of a link or loopback under test, and its outputs drive status LEDs or counters.

---
 rtl/lfsr_10_chk.sv | 96 +++++++++
 1 files changed

// File: rtl/lfsr_10_chk.sv
// lfsr_10_chk: self-synchronizing checker for the serial X^10+X^7+1 PRBS stream.
// Seeds from received bits, verifies a run of predictions, then flywheels and counts errors.
module lfsr_10_chk #(
  parameter int LOCK_CNT = 16,
  parameter int LOSS_CNT = 4,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  input  logic             clr_i,
  output logic             lock_o,
  output logic             err_o,
  output logic [ERR_W-1:0] err_cnt_o
);
  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;
  state_t           r_state, w_state_nxt;
  logic [9:0]       r_h, w_h_nxt;
  logic [3:0]       r_seed_cnt, w_seed_nxt;
  logic [7:0]       r_run_cnt, w_run_nxt;
  logic [3:0]       r_miss_cnt, w_miss_nxt;
  logic             r_lock, r_err, w_err, w_p, w_miss;
  logic [ERR_W-1:0] r_err_cnt;
  assign w_p       = r_h[7] ^ r_h[0];
  assign w_miss    = bit_i ^ w_p;
  assign lock_o    = r_lock;
  assign err_o     = r_err;
  assign err_cnt_o = r_err_cnt;
  always_comb begin
    w_state_nxt = r_state;
    w_h_nxt     = r_h;
    w_seed_nxt  = r_seed_cnt;
    w_run_nxt   = r_run_cnt;
    w_miss_nxt  = r_miss_cnt;
    w_err       = 1'b0;
    if (bit_valid_i) begin
      // once locked the register runs on its own predictions so a channel error is not shifted in
      w_h_nxt = {(r_state == LOCKED) ? w_p : bit_i, r_h[9:1]};
      case (r_state)
        SEED: begin
          w_seed_nxt = r_seed_cnt + 4'd1;
          if (r_seed_cnt == 4'd9) begin
            w_state_nxt = VERIFY;
            w_seed_nxt  = '0;
            w_run_nxt   = '0;
          end
        end
        VERIFY: begin
          if (w_miss || r_h == 10'd0) begin
            w_state_nxt = SEED;
            w_seed_nxt  = '0;
          end else begin
            w_run_nxt = r_run_cnt + 8'd1;
            if (w_run_nxt == 8'(LOCK_CNT)) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end
        end
        LOCKED: begin
          w_err      = w_miss;
          w_miss_nxt = w_miss ? r_miss_cnt + 4'd1 : '0;
          if (w_miss && w_miss_nxt == 4'(LOSS_CNT)) begin
            w_state_nxt = SEED;
            w_seed_nxt  = '0;
          end
        end
        default: w_state_nxt = SEED;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SEED;
    else        r_state <= w_state_nxt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h        <= '0;
      r_seed_cnt <= '0;
      r_run_cnt  <= '0;
      r_miss_cnt <= '0;
      r_lock     <= 1'b0;
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
    end else begin
      r_h        <= w_h_nxt;
      r_seed_cnt <= w_seed_nxt;
      r_run_cnt  <= w_run_nxt;
      r_miss_cnt <= w_miss_nxt;
      r_lock     <= w_state_nxt == LOCKED;
      r_err      <= w_err;
      r_err_cnt  <= clr_i ? '0 : (w_err && !(&r_err_cnt)) ? r_err_cnt + ERR_W'(1) : r_err_cnt;
    end
  end
endmodule
